// File: rtl/led_pattern_if.sv
// led_pattern_if: single-cycle channel configuration write port.
//   wr_en   - write strobe, one cycle
//   wr_ch   - target channel index
//   wr_mode - 0=OFF, 1=ON, 2=BLINK, 3=BREATHE
//   wr_rate - ticks per step minus one
interface led_pattern_if #(
   parameter int CH_BITS   = 2,
   parameter int RATE_BITS = 8
);
   logic                 wr_en;
   logic [CH_BITS-1:0]   wr_ch;
   logic [1:0]           wr_mode;
   logic [RATE_BITS-1:0] wr_rate;
   modport master (output wr_en, wr_ch, wr_mode, wr_rate);
   modport slave  (input  wr_en, wr_ch, wr_mode, wr_rate);
endinterface

// File: rtl/led_pattern.sv
// led_pattern: multi-channel LED pattern generator (off / on / blink / breathe).
//   clk  - system clock
//   rst  - synchronous active-high reset
//   wr   - configuration write port (slave)
//   led  - registered LED drive, bit i = channel i
//   tick - one-cycle timebase pulse every PRESCALE clocks
module led_pattern #(
   parameter int CHANNELS  = 3,
   parameter int PRESCALE  = 12000,
   parameter int PWM_BITS  = 8,
   parameter int RATE_BITS = 8,
   parameter int CH_BITS   = 2
) (
   input  logic                clk,
   input  logic                rst,
   led_pattern_if.slave        wr,
   output logic [CHANNELS-1:0] led,
   output logic                tick
);
   localparam int PRE_W = $clog2(PRESCALE);
   localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [PWM_BITS-1:0] MAX       = '1;
   localparam logic [1:0]          M_ON      = 2'd1;
   localparam logic [1:0]          M_BLINK   = 2'd2;
   localparam logic [1:0]          M_BREATHE = 2'd3;

   logic [PRE_W-1:0]                         pre_q, pre_d;
   logic                                     tick_q, tick_d;
   logic [PWM_BITS-1:0]                      pwm_q, pwm_d;
   logic [CHANNELS-1:0][1:0]                 mode_q, mode_d;
   logic [CHANNELS-1:0][RATE_BITS-1:0]       rate_q, rate_d;
   logic [CHANNELS-1:0][RATE_BITS-1:0]       rcnt_q, rcnt_d;
   logic [CHANNELS-1:0][PWM_BITS-1:0]        duty_q, duty_d;
   logic [CHANNELS-1:0]                      blink_q, blink_d;
   logic [CHANNELS-1:0]                      dir_q, dir_d;
   logic [CHANNELS-1:0]                      led_q, led_d;
   logic [CHANNELS-1:0]                      step, hit, br_step;

   always_comb begin
      pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      tick_d  = pre_q == PRE_LAST;
      pwm_d   = pwm_q + 1'b1;
      mode_d  = mode_q;
      rate_d  = rate_q;
      rcnt_d  = rcnt_q;
      duty_d  = duty_q;
      blink_d = blink_q;
      dir_d   = dir_q;
      led_d   = '0;
      step    = '0;
      hit     = '0;
      br_step = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         step[i]    = tick_q && (rcnt_q[i] == rate_q[i]);
         // an index >= CHANNELS never matches, so such writes are dropped
         hit[i]     = wr.wr_en && (wr.wr_ch == CH_BITS'(i));
         br_step[i] = step[i] && (mode_q[i] == M_BREATHE);
         mode_d[i]  = hit[i] ? wr.wr_mode : mode_q[i];
         rate_d[i]  = hit[i] ? wr.wr_rate : rate_q[i];
         // a write on a tick edge takes precedence over that channel's step
         rcnt_d[i]  = (hit[i] || step[i]) ? '0 : tick_q ? rcnt_q[i] + 1'b1 : rcnt_q[i];
         blink_d[i] = !hit[i] && ((step[i] && mode_q[i] == M_BLINK) ? !blink_q[i] : blink_q[i]);
         duty_d[i]  = hit[i] ? '0 : !br_step[i] ? duty_q[i] :
                      dir_q[i] ? duty_q[i] + 1'b1 : duty_q[i] - 1'b1;
         // turn around at the triangle peaks; dir=1 means counting up
         dir_d[i]   = hit[i] || (br_step[i] ? (dir_q[i] ? (duty_q[i] != MAX - 1'b1)
                                                        : (duty_q[i] == PWM_BITS'(1)))
                                            : dir_q[i]);
         led_d[i]   = (mode_q[i] == M_ON) ||
                      (mode_q[i] == M_BLINK && blink_q[i]) ||
                      (mode_q[i] == M_BREATHE && pwm_q < duty_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q   <= '0;
         tick_q  <= 1'b0;
         pwm_q   <= '0;
         mode_q  <= '0;
         rate_q  <= '0;
         rcnt_q  <= '0;
         duty_q  <= '0;
         blink_q <= '0;
         dir_q   <= '1;
         led_q   <= '0;
      end else begin
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         pwm_q   <= pwm_d;
         mode_q  <= mode_d;
         rate_q  <= rate_d;
         rcnt_q  <= rcnt_d;
         duty_q  <= duty_d;
         blink_q <= blink_d;
         dir_q   <= dir_d;
         led_q   <= led_d;
      end
   end

   assign led  = led_q;
   assign tick = tick_q;
endmodule

// File: tb/tb_led_pattern.sv
// tb_led_pattern: directed self-checking bench for led_pattern.
//   dut_a - 3 channels, PRESCALE=4, PWM_BITS=8
//   dut_b - 3 channels, PRESCALE=2, PWM_BITS=3 (short breathe triangle)
module tb_led_pattern;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] led_a, led_b;
   logic       tick_a, tick_b;
   int         k = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   led_pattern_if #(.CH_BITS(2), .RATE_BITS(8)) ifa ();
   led_pattern_if #(.CH_BITS(2), .RATE_BITS(8)) ifb ();

   led_pattern #(.CHANNELS(3), .PRESCALE(4), .PWM_BITS(8), .RATE_BITS(8), .CH_BITS(2)) dut_a (
      .clk(clk), .rst(rst), .wr(ifa), .led(led_a), .tick(tick_a));
   led_pattern #(.CHANNELS(3), .PRESCALE(2), .PWM_BITS(3), .RATE_BITS(8), .CH_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .wr(ifb), .led(led_b), .tick(tick_b));

   always #5 clk = ~clk;

   task automatic adv();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      k = 0;
   endtask

   task automatic wa(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] rate);
      ifa.wr_en = 1'b1; ifa.wr_ch = ch; ifa.wr_mode = mode; ifa.wr_rate = rate;
      adv();
      ifa.wr_en = 1'b0;
   endtask

   task automatic wb(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] rate);
      ifb.wr_en = 1'b1; ifb.wr_ch = ch; ifb.wr_mode = mode; ifb.wr_rate = rate;
      adv();
      ifb.wr_en = 1'b0;
   endtask

   function automatic int tri_duty(input int j);
      int m = j % 14;
      return (m <= 7) ? m : 14 - m;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         adv();
         n_chk++;
         if (led_a !== 3'b000 || tick_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d got led=%b tick=%b exp led=000 tick=0", i, led_a, tick_a);
         end
      end
      rst = 1'b0;
      k = 0;
      for (int i = 0; i < 12; i++) begin
         adv();
         n_chk++;
         if (tick_a !== (k % 4 == 0)) begin
            n_fail++;
            $display("FAIL reset_tick cyc %0d got %b exp %b", k, tick_a, (k % 4 == 0));
         end
      end
   endtask

   task automatic test_on_off();
      do_reset();
      wa(2'd1, 2'd1, 8'd0);
      n_chk++;
      if (led_a !== 3'b000) begin n_fail++; $display("FAIL on_lat1 got %b exp 000", led_a); end
      adv();
      n_chk++;
      if (led_a !== 3'b010) begin n_fail++; $display("FAIL on_lat2 got %b exp 010", led_a); end
      wa(2'd3, 2'd0, 8'd0);
      adv();
      n_chk++;
      if (led_a !== 3'b010) begin n_fail++; $display("FAIL bad_ch_off got %b exp 010", led_a); end
      wa(2'd1, 2'd0, 8'd0);
      adv();
      n_chk++;
      if (led_a !== 3'b000) begin n_fail++; $display("FAIL off got %b exp 000", led_a); end
      wa(2'd3, 2'd1, 8'd0);
      for (int i = 0; i < 3; i++) begin
         adv();
         n_chk++;
         if (led_a !== 3'b000) begin n_fail++; $display("FAIL bad_ch_on got %b exp 000", led_a); end
      end
   endtask

   task automatic test_blink();
      logic e;
      do_reset();
      wa(2'd0, 2'd2, 8'd1);
      for (int i = 2; i <= 40; i++) begin
         adv();
         e = (k >= 10) && (((k - 10) / 8) % 2 == 0);
         n_chk++;
         if (led_a !== {2'b00, e}) begin
            n_fail++;
            $display("FAIL blink cyc %0d got %b exp %b", k, led_a, {2'b00, e});
         end
      end
   endtask

   task automatic test_breathe();
      logic e;
      int c0, c1, c3;
      do_reset();
      wb(2'd2, 2'd3, 8'd0);
      for (int i = 2; i <= 64; i++) begin
         adv();
         e = ((k - 1) % 8) < tri_duty((k - 2) / 2);
         n_chk++;
         if (led_b !== {e, 2'b00}) begin
            n_fail++;
            $display("FAIL breathe cyc %0d got %b exp %b", k, led_b, {e, 2'b00});
         end
      end
      do_reset();
      wb(2'd2, 2'd3, 8'd15);
      c0 = 0; c1 = 0; c3 = 0;
      while (k < 107) begin
         adv();
         if (k >= 26 && k <= 33) c0 += int'(led_b[2]);
         if (k >= 34 && k <= 41) c1 += int'(led_b[2]);
         if (k >= 100 && k <= 107) c3 += int'(led_b[2]);
      end
      n_chk++;
      if (c0 !== 0) begin n_fail++; $display("FAIL duty0_highs got %0d exp 0", c0); end
      n_chk++;
      if (c1 !== 1) begin n_fail++; $display("FAIL duty1_highs got %0d exp 1", c1); end
      n_chk++;
      if (c3 !== 3) begin n_fail++; $display("FAIL duty3_highs got %0d exp 3", c3); end
   endtask

   task automatic test_write_on_tick();
      do_reset();
      wa(2'd0, 2'd2, 8'd0);
      while (k < 12) begin
         adv();
         if (k == 6 || k == 10) begin
            n_chk++;
            if (led_a !== ((k == 6) ? 3'b001 : 3'b000)) begin
               n_fail++;
               $display("FAIL wot_pre cyc %0d got %b", k, led_a);
            end
         end
      end
      n_chk++;
      if (tick_a !== 1'b1) begin n_fail++; $display("FAIL wot_tick got %b exp 1", tick_a); end
      wa(2'd0, 2'd2, 8'd0);
      for (int i = 14; i <= 18; i++) begin
         adv();
         n_chk++;
         if (led_a !== ((k == 18) ? 3'b001 : 3'b000)) begin
            n_fail++;
            $display("FAIL wot cyc %0d got %b exp %b", k, led_a, (k == 18) ? 3'b001 : 3'b000);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      wb(2'd0, 2'd3, 8'd0);
      wb(2'd1, 2'd1, 8'd0);
      while (k < 11) adv();
      n_chk++;
      if (led_b[1] !== 1'b1) begin n_fail++; $display("FAIL mid_on got %b exp 1", led_b[1]); end
      rst = 1'b1;
      ifb.wr_en = 1'b1; ifb.wr_ch = 2'd1; ifb.wr_mode = 2'd1; ifb.wr_rate = 8'd0;
      adv();
      rst = 1'b0;
      ifb.wr_en = 1'b0;
      n_chk++;
      if (led_b !== 3'b000 || tick_b !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst got led=%b tick=%b exp led=000 tick=0", led_b, tick_b);
      end
      for (int i = 0; i < 20; i++) begin
         adv();
         n_chk++;
         if (led_b !== 3'b000) begin n_fail++; $display("FAIL mid_after cyc %0d got %b exp 000", i, led_b); end
      end
   endtask

   initial begin
      ifa.wr_en = 1'b0; ifa.wr_ch = '0; ifa.wr_mode = '0; ifa.wr_rate = '0;
      ifb.wr_en = 1'b0; ifb.wr_ch = '0; ifb.wr_mode = '0; ifb.wr_rate = '0;
      test_reset();
      test_on_off();
      test_blink();
      test_breathe();
      test_write_on_tick();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/led_pattern.md
Name: led_pattern

Overview:
Parametrised multi-channel LED pattern generator. It supersedes the free-running-counter blinker with per-channel programmable modes (off, on, blink, breathe) and per-channel rates. A shared prescaler produces a slow timebase tick. A shared free-running PWM counter drives the breathe mode. A simple single-cycle write port configures each channel; it is intended to be driven from the board top or a future register block.

Parameters:
CHANNELS, 3, number of independent LED outputs (1..16).
PRESCALE, 12000, clk cycles per timebase tick (>=2); 12000 gives a 1 kHz tick at 12 MHz.
PWM_BITS, 8, PWM counter and breathe duty width; MAX = 2^PWM_BITS-1.
RATE_BITS, 8, width of the per-channel rate divider.
CH_BITS, 2, width of wr_ch; must be >= clog2(CHANNELS), minimum 1.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
wr_en  input  1  config write strobe, one cycle.
wr_ch  input  CH_BITS  target channel index.
wr_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=BREATHE.
wr_rate  input  RATE_BITS  ticks per step minus one.
led  output  CHANNELS  registered LED drive, bit i = channel i.
tick  output  1  one-cycle timebase pulse (debug/chaining).

Behaviour:
- Reset (rst=1 at posedge): all modes OFF; rate, rate_cnt, duty, blink_state = 0; dir = up; pre_cnt = 0; pwm_cnt = 0; led = 0; tick = 0. Reset overrides a simultaneous wr_en. Reset applied mid-pattern has the same effect; there is no retained state.
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps to 0. Registered tick = 1 for exactly the cycle after pre_cnt == PRESCALE-1. The first tick after reset is high on cycle PRESCALE.
- PWM: pwm_cnt increments every clk and wraps MAX->0 (period 2^PWM_BITS clocks).
- Write: wr_en with wr_ch < CHANNELS loads mode and rate. The same edge clears that channel's rate_cnt, duty and blink_state and sets dir = up. wr_ch >= CHANNELS is ignored. A write coinciding with a tick wins over the tick step for that channel. Other channels are unaffected.
- Step event per channel: on tick, if rate_cnt == rate then step and rate_cnt <= 0, else rate_cnt <= rate_cnt+1. One step occurs every rate+1 ticks. rate_cnt advances in every mode.
- OFF: led[i] = 0. ON: led[i] = 1.
- BLINK: each step toggles blink_state. led[i] = blink_state, so the half-period is (rate+1)*PRESCALE clocks.
- BREATHE:
  - Step with dir up: duty <= duty+1; if duty+1 == MAX, dir <= down.
  - Step with dir down: duty <= duty-1; if duty-1 == 0, dir <= up.
  - Full triangle = 2*MAX steps.
  - led[i] = (pwm_cnt < duty). Duty 0 is constant off; duty MAX is on for MAX of every 2^PWM_BITS clocks.
- Latency:
  - led is registered and reflects state one cycle after the state changes.
  - ON/OFF writes are visible on led 2 cycles after the wr_en edge (write edge, then output register).
- No combinational path from inputs to outputs.

Test Plan:
1. Reset: PRESCALE=4; hold rst 3 cycles, release -> led=0 and tick=0 throughout reset; tick first high on cycle 4 after release, then every 4 cycles.
2. ON/OFF: write ch1 mode=1 -> led=3'b010 two cycles later; write ch1 mode=0 -> led=0; write wr_ch=3 mode=1 -> led unchanged.
3. Blink: PRESCALE=4, ch0 mode=2, rate=1 -> led[0] toggles every 8 clk; period 16; ch1/ch2 stay 0.
4. Breathe: PRESCALE=2, PWM_BITS=3, ch2 mode=3, rate=0 -> duty goes 0,1..7,6..0,1 with one step per tick; at duty=3, led[2] is high for 3 of every 8 clk; at duty=0 it stays low.
5. Write on tick: issue wr_en to ch0 (BLINK, rate=0) on the same edge as tick -> blink_state stays 0 on that edge; first toggle occurs on the next tick.
6. Reset mid-pattern: ch0 breathing at duty=5, ch1 ON, assert rst 1 cycle -> led=0 next cycle; modes OFF; no output until rewritten.
